// File: rtl/bvf_pkg.sv
// rtl/bvf_pkg.sv - shared mode encodings and lane packing helper for the BVF pipe array
package bvf_pkg;

    localparam logic [1:0] MODE_BVF  = 2'b00;
    localparam logic [1:0] MODE_COPY = 2'b01;
    localparam logic [1:0] MODE_PASS = 2'b10;
    localparam logic [1:0] MODE_RSVD = 2'b11;

    // Lane k of a packed operand occupies bits [k*width +: width].
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/bvf_lane.sv
// rtl/bvf_lane.sv - combinational BVF-style reversible transform for one WIDTH-bit lane
module bvf_lane
    import bvf_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] w,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] z,
    output logic             err
);

    // The reserved mode falls through to the BVF transform and is only flagged.
    always_comb begin
        w = a;
        x = a ^ b;
        y = c;
        z = d ^ c;
        case (mode)
            MODE_COPY: begin
                x = a;
                z = c;
            end
            MODE_PASS: begin
                x = b;
                z = d;
            end
            default: ;
        endcase
    end

    assign err = (mode == MODE_RSVD);

endmodule

// File: rtl/bvf_pipe_array.sv
// rtl/bvf_pipe_array.sv - LANES-wide BVF transform carried through a STAGES-deep valid/ready pipeline
module bvf_pipe_array
    import bvf_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int LANES  = 4,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             in_mode,
    input  logic [LANES*WIDTH-1:0] in_a,
    input  logic [LANES*WIDTH-1:0] in_b,
    input  logic [LANES*WIDTH-1:0] in_c,
    input  logic [LANES*WIDTH-1:0] in_d,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_w,
    output logic [LANES*WIDTH-1:0] out_x,
    output logic [LANES*WIDTH-1:0] out_y,
    output logic [LANES*WIDTH-1:0] out_z,
    output logic                   out_err,
    output logic [CNT_W-1:0]       tx_count
);

    localparam int LW = LANES * WIDTH;
    localparam int DW = 4 * LW + 1;

    logic [LW-1:0]     xf_w, xf_x, xf_y, xf_z;
    logic [LANES-1:0]  lane_err;
    logic [DW-1:0]     in_word;

    logic [STAGES-1:0] stage_valid;
    logic [DW-1:0]     stage_data [STAGES];
    logic [STAGES-1:0] stage_load;
    logic [STAGES-1:0] chain_valid;
    logic [DW-1:0]     chain_data [STAGES];

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        bvf_lane #(.WIDTH(WIDTH)) u_lane (
            .a    (in_a[lane_lsb(k, WIDTH) +: WIDTH]),
            .b    (in_b[lane_lsb(k, WIDTH) +: WIDTH]),
            .c    (in_c[lane_lsb(k, WIDTH) +: WIDTH]),
            .d    (in_d[lane_lsb(k, WIDTH) +: WIDTH]),
            .mode (in_mode),
            .w    (xf_w[lane_lsb(k, WIDTH) +: WIDTH]),
            .x    (xf_x[lane_lsb(k, WIDTH) +: WIDTH]),
            .y    (xf_y[lane_lsb(k, WIDTH) +: WIDTH]),
            .z    (xf_z[lane_lsb(k, WIDTH) +: WIDTH]),
            .err  (lane_err[k])
        );
    end

    assign in_word = {|lane_err, xf_w, xf_x, xf_y, xf_z};

    // Stage i may load unless it and every stage after it are full while the output stalls.
    always_comb begin
        logic all_full;
        all_full   = 1'b1;
        stage_load = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            all_full      = all_full & stage_valid[i];
            stage_load[i] = out_ready | ~all_full;
        end
    end

    assign in_ready = stage_load[0];

    always_comb begin
        chain_valid[0] = in_valid;
        chain_data[0]  = in_word;
        for (int i = 1; i < STAGES; i++) begin
            chain_valid[i] = stage_valid[i-1];
            chain_data[i]  = stage_data[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage_valid <= '0;
            tx_count    <= '0;
            for (int i = 0; i < STAGES; i++) begin
                stage_data[i] <= '0;
            end
        end else begin
            if (in_valid && in_ready) begin
                tx_count <= tx_count + CNT_W'(1);
            end
            for (int i = 0; i < STAGES; i++) begin
                if (stage_load[i]) begin
                    stage_valid[i] <= chain_valid[i];
                    if (chain_valid[i]) begin
                        stage_data[i] <= chain_data[i];
                    end
                end
            end
        end
    end

    assign out_valid = stage_valid[STAGES-1];
    assign out_err   = stage_data[STAGES-1][DW-1];
    assign out_w     = stage_data[STAGES-1][4*LW-1 -: LW];
    assign out_x     = stage_data[STAGES-1][3*LW-1 -: LW];
    assign out_y     = stage_data[STAGES-1][2*LW-1 -: LW];
    assign out_z     = stage_data[STAGES-1][LW-1:0];

endmodule
